// File: rtl/rst_sequencer.sv
// Reset release sequencer for the PLL-derived clock domains: waits for a stable
// lock, releases domain resets one stage at a time, re-sequences on lock loss or software request.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// ST_WAIT_LOCK | all domains held in reset, counting consecutive lock cycles
// ST_RELEASE   | releasing domains in index order, one every STAGE_DELAY cycles
// ST_RUN       | every domain released, software requests accepted here
// ST_SW_HOLD   | software reset: all domains held for STAGE_DELAY cycles
module rst_sequencer #(
    parameter int N_DOMAINS   = 4,
    parameter int LOCK_STABLE = 255,
    parameter int STAGE_DELAY = 16,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pll_lock,
    input  logic                 sw_rst_req,
    output logic                 sw_rst_ack,
    input  logic                 lock_lost_clr,
    output logic [N_DOMAINS-1:0] n_reset_out,
    output logic                 all_ready,
    output logic                 lock_lost,
    output logic [1:0]           state_dbg
);

    localparam int KW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_RUN       = 2'd2,
        ST_SW_HOLD   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     lock_cnt, lock_cnt_nxt;
    logic [CNT_W-1:0]     stage_cnt, stage_cnt_nxt;
    logic [KW-1:0]        k, k_nxt;
    logic [N_DOMAINS-1:0] n_reset_nxt;
    logic                 all_ready_nxt, ack_nxt, lock_lost_nxt;
    logic                 pending, pending_nxt, armed, armed_nxt;
    logic                 accept;

    assign state_dbg = state;
    assign accept    = sw_rst_req && armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT_LOCK;
            lock_cnt    <= '0;
            stage_cnt   <= '0;
            k           <= '0;
            n_reset_out <= '0;
            all_ready   <= 1'b0;
            sw_rst_ack  <= 1'b0;
            lock_lost   <= 1'b0;
            pending     <= 1'b0;
            armed       <= 1'b1;
        end else begin
            state       <= state_nxt;
            lock_cnt    <= lock_cnt_nxt;
            stage_cnt   <= stage_cnt_nxt;
            k           <= k_nxt;
            n_reset_out <= n_reset_nxt;
            all_ready   <= all_ready_nxt;
            sw_rst_ack  <= ack_nxt;
            lock_lost   <= lock_lost_nxt;
            pending     <= pending_nxt;
            armed       <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lock_cnt_nxt  = lock_cnt;
        stage_cnt_nxt = stage_cnt;
        k_nxt         = k;
        n_reset_nxt   = n_reset_out;
        all_ready_nxt = all_ready;
        ack_nxt       = 1'b0;
        lock_lost_nxt = lock_lost;
        pending_nxt   = pending;
        armed_nxt     = armed;

        if (!sw_rst_req) armed_nxt = 1'b1;
        if (lock_lost_clr) lock_lost_nxt = 1'b0;

        if (state == ST_WAIT_LOCK) begin
            n_reset_nxt   = '0;
            all_ready_nxt = 1'b0;
            if (!pll_lock) begin
                lock_cnt_nxt = '0;
            end else if (lock_cnt == CNT_W'(LOCK_STABLE - 1)) begin
                state_nxt     = ST_RELEASE;
                lock_cnt_nxt  = '0;
                stage_cnt_nxt = '0;
                k_nxt         = '0;
            end else begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
        end else if (!pll_lock) begin
            // Lock loss outranks a software request, but a request accepted on
            // the same cycle is remembered so its ack still arrives.
            state_nxt     = ST_WAIT_LOCK;
            n_reset_nxt   = '0;
            all_ready_nxt = 1'b0;
            lock_cnt_nxt  = '0;
            stage_cnt_nxt = '0;
            k_nxt         = '0;
            lock_lost_nxt = 1'b1;
            if (state == ST_RUN && accept) begin
                pending_nxt = 1'b1;
                armed_nxt   = 1'b0;
            end
        end else begin
            unique case (state)
                ST_RELEASE: begin
                    if (stage_cnt == CNT_W'(STAGE_DELAY - 1)) begin
                        n_reset_nxt[k] = 1'b1;
                        stage_cnt_nxt  = '0;
                        if (k == KW'(N_DOMAINS - 1)) begin
                            state_nxt     = ST_RUN;
                            all_ready_nxt = 1'b1;
                            ack_nxt       = pending;
                            pending_nxt   = 1'b0;
                        end else begin
                            k_nxt = k + KW'(1);
                        end
                    end else begin
                        stage_cnt_nxt = stage_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        state_nxt     = ST_SW_HOLD;
                        pending_nxt   = 1'b1;
                        armed_nxt     = 1'b0;
                        n_reset_nxt   = '0;
                        all_ready_nxt = 1'b0;
                        stage_cnt_nxt = '0;
                        k_nxt         = '0;
                    end
                end
                ST_SW_HOLD: begin
                    if (stage_cnt == CNT_W'(STAGE_DELAY - 1)) begin
                        state_nxt     = ST_RELEASE;
                        stage_cnt_nxt = '0;
                    end else begin
                        stage_cnt_nxt = stage_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = ST_WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues expected output snapshots
// per cycle, a negedge monitor pops and compares them.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       lock_lost_clr = 1'b0;
    logic       sw_rst_ack;
    logic [3:0] n_reset_out;
    logic       all_ready;
    logic       lock_lost;
    logic [1:0] state_dbg;

    localparam logic [1:0] WL = 2'd0, RL = 2'd1, RN = 2'd2, SH = 2'd3;

    typedef struct packed {
        int         tick;
        logic [8:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur;
    string cur_name;
    logic [8:0] got;
    int tick = 0;
    int t0 = 0;
    int checks = 0;
    int errors = 0;
    int ack_seen = 0;

    rst_sequencer #(
        .N_DOMAINS(4),
        .LOCK_STABLE(8),
        .STAGE_DELAY(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_lock(pll_lock),
        .sw_rst_req(sw_rst_req),
        .sw_rst_ack(sw_rst_ack),
        .lock_lost_clr(lock_lost_clr),
        .n_reset_out(n_reset_out),
        .all_ready(all_ready),
        .lock_lost(lock_lost),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    always @(negedge clk) begin
        if (sw_rst_ack === 1'b1) ack_seen++;
        got = {n_reset_out, all_ready, lock_lost, sw_rst_ack, state_dbg};
        while (exp_q.size() > 0 && exp_q[0].tick <= tick) begin
            cur      = exp_q.pop_front();
            cur_name = name_q.pop_front();
            checks++;
            if (cur.tick != tick) begin
                errors++;
                $display("FAIL %s: snapshot at tick %0d not sampled (now %0d)", cur_name, cur.tick, tick);
            end else if (got !== cur.val) begin
                errors++;
                $display("FAIL %s: got nrst=%b rdy=%b lost=%b ack=%b st=%0d, want nrst=%b rdy=%b lost=%b ack=%b st=%0d",
                         cur_name, got[8:5], got[4], got[3], got[2], got[1:0],
                         cur.val[8:5], cur.val[4], cur.val[3], cur.val[2], cur.val[1:0]);
            end
        end
    end

    task automatic expect_at(input int t, input logic [3:0] n, input logic r, input logic l,
                             input logic a, input logic [1:0] s, input string nm);
        exp_t e;
        e.tick = t0 + t;
        e.val  = {n, r, l, a, s};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_to(input int t);
        while (tick < t0 + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset is sampled on the next edge; that edge is t=0 for the test.
    task automatic start_test(input logic lock);
        reset = 1'b1;
        sw_rst_req = 1'b0;
        lock_lost_clr = 1'b0;
        pll_lock = lock;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t0 = tick;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        // 1: clean power-up
        start_test(1'b1);
        expect_at(0,  4'b0000, 0, 0, 0, WL, "t1_reset");
        expect_at(7,  4'b0000, 0, 0, 0, WL, "t1_wait7");
        expect_at(8,  4'b0000, 0, 0, 0, RL, "t1_rel8");
        expect_at(11, 4'b0000, 0, 0, 0, RL, "t1_rel11");
        expect_at(12, 4'b0001, 0, 0, 0, RL, "t1_b0");
        expect_at(16, 4'b0011, 0, 0, 0, RL, "t1_b1");
        expect_at(20, 4'b0111, 0, 0, 0, RL, "t1_b2");
        expect_at(23, 4'b0111, 0, 0, 0, RL, "t1_pre_run");
        expect_at(24, 4'b1111, 1, 0, 0, RN, "t1_run");
        wait_to(26);

        // 2+3: lock glitch during WAIT_LOCK, then lock loss in RUN and clear
        start_test(1'b1);
        expect_at(6,  4'b0000, 0, 0, 0, WL, "t2_glitch");
        expect_at(13, 4'b0000, 0, 0, 0, WL, "t2_wait13");
        expect_at(14, 4'b0000, 0, 0, 0, RL, "t2_rel14");
        expect_at(29, 4'b0111, 0, 0, 0, RL, "t2_pre_run");
        expect_at(30, 4'b1111, 1, 0, 0, RN, "t2_run");
        expect_at(41, 4'b0000, 0, 1, 0, WL, "t3_loss");
        expect_at(48, 4'b0000, 0, 1, 0, WL, "t3_wait48");
        expect_at(49, 4'b0000, 0, 1, 0, RL, "t3_rel49");
        expect_at(65, 4'b1111, 1, 1, 0, RN, "t3_run");
        expect_at(66, 4'b1111, 1, 1, 0, RN, "t3_sticky");
        expect_at(68, 4'b1111, 1, 0, 0, RN, "t3_clr");
        wait_to(5);  pll_lock = 1'b0;
        wait_to(6);  pll_lock = 1'b1;
        wait_to(40); pll_lock = 1'b0;
        wait_to(41); pll_lock = 1'b1;
        wait_to(67); lock_lost_clr = 1'b1;
        wait_to(68); lock_lost_clr = 1'b0;
        wait_to(70);

        // 4+5: software reset, then lock drop together with a request
        start_test(1'b1);
        expect_at(24, 4'b1111, 1, 0, 0, RN, "t4_run");
        expect_at(31, 4'b0000, 0, 0, 0, SH, "t4_hold");
        expect_at(34, 4'b0000, 0, 0, 0, SH, "t4_hold_end");
        expect_at(35, 4'b0000, 0, 0, 0, RL, "t4_rel35");
        expect_at(39, 4'b0001, 0, 0, 0, RL, "t4_b0");
        expect_at(43, 4'b0011, 0, 0, 0, RL, "t4_b1");
        expect_at(47, 4'b0111, 0, 0, 0, RL, "t4_b2");
        expect_at(50, 4'b0111, 0, 0, 0, RL, "t4_pre_ack");
        expect_at(51, 4'b1111, 1, 0, 1, RN, "t4_ack");
        expect_at(52, 4'b1111, 1, 0, 0, RN, "t4_ack_once");
        expect_at(55, 4'b1111, 1, 0, 0, RN, "t4_no_retrig");
        expect_at(57, 4'b1111, 1, 0, 0, RN, "t4_released");
        expect_at(61, 4'b0000, 0, 1, 0, WL, "t5_loss");
        expect_at(68, 4'b0000, 0, 1, 0, WL, "t5_wait68");
        expect_at(69, 4'b0000, 0, 1, 0, RL, "t5_rel69");
        expect_at(84, 4'b0111, 0, 1, 0, RL, "t5_pre_ack");
        expect_at(85, 4'b1111, 1, 1, 1, RN, "t5_ack");
        expect_at(86, 4'b1111, 1, 1, 0, RN, "t5_ack_once");
        expect_at(90, 4'b1111, 1, 1, 0, RN, "t5_settled");
        wait_to(30); sw_rst_req = 1'b1;
        wait_to(56); sw_rst_req = 1'b0;
        wait_to(60); sw_rst_req = 1'b1; pll_lock = 1'b0;
        wait_to(61); pll_lock = 1'b1;
        wait_to(86); sw_rst_req = 1'b0;
        wait_to(92);

        // 6: block reset in the middle of RELEASE
        start_test(1'b1);
        expect_at(16, 4'b0011, 0, 0, 0, RL, "t6_b1");
        expect_at(17, 4'b0011, 0, 0, 0, RL, "t6_before");
        expect_at(18, 4'b0000, 0, 0, 0, WL, "t6_abort");
        expect_at(25, 4'b0000, 0, 0, 0, WL, "t6_wait25");
        expect_at(26, 4'b0000, 0, 0, 0, RL, "t6_rel26");
        expect_at(42, 4'b1111, 1, 0, 0, RN, "t6_run");
        wait_to(17); reset = 1'b1;
        wait_to(18); reset = 1'b0;
        wait_to(45);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d snapshots left, want 0", exp_q.size());
        end
        checks++;
        if (ack_seen != 2) begin
            errors++;
            $display("FAIL ack_count: got %0d ack pulses, want 2", ack_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
